// File: rtl/bfly_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bfly_pkg
// Description : Shared constants and types for the butterfly output merger.
// Revision    : 1.0  initial release
// ============================================================================
package bfly_pkg;

  localparam logic [1:0] MODE_FIXED_A = 2'd0;
  localparam logic [1:0] MODE_RR      = 2'd1;
  localparam logic [1:0] MODE_BURST   = 2'd2;
  localparam logic [1:0] MODE_RSVD    = 2'd3;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

endpackage
`default_nettype wire

// File: rtl/bfly_out_chnl_merge.sv
`default_nettype none
// ============================================================================
// Module      : bfly_out_chnl_merge
// Description : One channel: A/B arbiter, burst lock and show-ahead output FIFO.
// Revision    : 1.0  initial release
// ============================================================================
module bfly_out_chnl_merge
  import bfly_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 16,
  parameter int BLEN_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    cfg_mode_i,
  input  logic [BLEN_W-1:0]             cfg_burst_len_i,
  input  logic                          vld_a_i,
  input  logic [DATA_WIDTH-1:0]         dat_a_i,
  output logic                          rdy_a_o,
  input  logic                          vld_b_i,
  input  logic [DATA_WIDTH-1:0]         dat_b_i,
  output logic                          rdy_b_o,
  output logic                          dn_vld_o,
  output logic [DATA_WIDTH-1:0]         dn_dat_o,
  output logic                          dn_src_o,
  output logic                          dn_last_o,
  input  logic                          dn_rdy_i,
  output logic [$clog2(DEPTH+1)-1:0]    level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);
  localparam int ENT_W = DATA_WIDTH + 2;

  lock_state_e        state_q, state_d;
  logic               grant_q, grant_d;
  logic               last_src_q;
  logic [1:0]         mode_q;
  logic [BLEN_W-1:0]  len_q;
  logic [BLEN_W-1:0]  cnt_q, cnt_d;
  logic [ENT_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q, level_d;

  logic [1:0]         mode_eff;
  logic [BLEN_W-1:0]  len_eff;
  logic               len_one, grant, full, empty, wr, rd, last_bit;
  logic [ENT_W-1:0]   rd_ent;

  always_comb begin
    mode_eff = (state_q == ST_LOCKED) ? mode_q : cfg_mode_i;
    len_eff  = (state_q == ST_LOCKED) ? len_q  : cfg_burst_len_i;
    len_one  = (len_eff < BLEN_W'(2));
    full     = (level_q == LVL_W'(DEPTH));
    empty    = (level_q == '0);

    grant = vld_a_i ? SRC_A : SRC_B;
    if (mode_eff == MODE_RR || mode_eff == MODE_BURST) begin
      if (vld_a_i && vld_b_i) grant = ~last_src_q;
      else if (vld_b_i)       grant = SRC_B;
      else                    grant = SRC_A;
    end
    if (state_q == ST_LOCKED) grant = grant_q;

    // rst gating keeps ready low while the channel is being cleared
    rdy_a_o = ~rst & ~full & (grant == SRC_A);
    rdy_b_o = ~rst & ~full & (grant == SRC_B);
    wr      = (rdy_a_o & vld_a_i) | (rdy_b_o & vld_b_i);
    rd      = ~empty & dn_rdy_i;

    last_bit = 1'b1;
    if (mode_eff == MODE_BURST && !len_one)
      last_bit = (state_q == ST_LOCKED) && (cnt_q == len_eff - BLEN_W'(1));

    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    if (wr && mode_eff == MODE_BURST && !len_one) begin
      if (state_q == ST_IDLE) begin
        state_d = ST_LOCKED;
        grant_d = grant;
        cnt_d   = BLEN_W'(1);
      end else if (last_bit) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + BLEN_W'(1);
      end
    end

    level_d = level_q;
    if (wr && !rd)      level_d = level_q + LVL_W'(1);
    else if (!wr && rd) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= SRC_A;
      last_src_q <= SRC_A;
      cnt_q      <= '0;
      mode_q     <= MODE_FIXED_A;
      len_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      // Shadow config only moves between bursts
      if (state_q == ST_IDLE) begin
        mode_q <= cfg_mode_i;
        len_q  <= cfg_burst_len_i;
      end
      if (wr) begin
        last_src_q <= grant;
        wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
      end
      if (rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= {last_bit, grant, (grant == SRC_B) ? dat_b_i : dat_a_i};
  end

  always_comb begin
    rd_ent    = mem_q[rd_ptr_q];
    dn_vld_o  = ~empty;
    dn_dat_o  = empty ? '0 : rd_ent[DATA_WIDTH-1:0];
    dn_src_o  = ~empty & rd_ent[DATA_WIDTH];
    dn_last_o = ~empty & rd_ent[DATA_WIDTH+1];
    level_o   = level_q;
  end

endmodule
`default_nettype wire

// File: rtl/bfly_output_merger.sv
`default_nettype none
// ============================================================================
// Module      : bfly_output_merger
// Description : Per-HBM-channel merge of butterfly ports A and B into one stream.
// Revision    : 1.0  initial release
// ============================================================================
module bfly_output_merger
  import bfly_pkg::*;
#(
  parameter int CHNL       = 8,
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 16,
  parameter int BLEN_W     = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [1:0]                         cfg_mode,
  input  logic [BLEN_W-1:0]                  cfg_burst_len,
  input  logic [CHNL-1:0]                    up_vld_A,
  input  logic [CHNL*DATA_WIDTH-1:0]         up_dat_A,
  output logic [CHNL-1:0]                    up_rdy_A,
  input  logic [CHNL-1:0]                    up_vld_B,
  input  logic [CHNL*DATA_WIDTH-1:0]         up_dat_B,
  output logic [CHNL-1:0]                    up_rdy_B,
  output logic [CHNL-1:0]                    dn_vld,
  output logic [CHNL*DATA_WIDTH-1:0]         dn_dat,
  output logic [CHNL-1:0]                    dn_src,
  output logic [CHNL-1:0]                    dn_last,
  input  logic [CHNL-1:0]                    dn_rdy,
  output logic [CHNL*$clog2(DEPTH+1)-1:0]    fifo_level
);

  localparam int LVL_W = $clog2(DEPTH+1);

  for (genvar g = 0; g < CHNL; g++) begin : g_chnl
    bfly_out_chnl_merge #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .BLEN_W     (BLEN_W)
    ) u_merge (
      .clk             (clk),
      .rst             (rst),
      .cfg_mode_i      (cfg_mode),
      .cfg_burst_len_i (cfg_burst_len),
      .vld_a_i         (up_vld_A[g]),
      .dat_a_i         (up_dat_A[g*DATA_WIDTH +: DATA_WIDTH]),
      .rdy_a_o         (up_rdy_A[g]),
      .vld_b_i         (up_vld_B[g]),
      .dat_b_i         (up_dat_B[g*DATA_WIDTH +: DATA_WIDTH]),
      .rdy_b_o         (up_rdy_B[g]),
      .dn_vld_o        (dn_vld[g]),
      .dn_dat_o        (dn_dat[g*DATA_WIDTH +: DATA_WIDTH]),
      .dn_src_o        (dn_src[g]),
      .dn_last_o       (dn_last[g]),
      .dn_rdy_i        (dn_rdy[g]),
      .level_o         (fifo_level[g*LVL_W +: LVL_W])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_bfly_output_merger.sv
`default_nettype none
// ============================================================================
// Module      : tb_bfly_output_merger
// Description : Directed and randomized self-checking bench for bfly_output_merger.
// Revision    : 1.0  initial release
// ============================================================================
module tb_bfly_output_merger;

  localparam int CHNL = 8;
  localparam int DW   = 256;
  localparam int LW   = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          cfg_mode;
  logic [7:0]          cfg_burst_len;
  logic [CHNL-1:0]     up_vld_A, up_rdy_A, up_vld_B, up_rdy_B;
  logic [CHNL*DW-1:0]  up_dat_A, up_dat_B, dn_dat;
  logic [CHNL-1:0]     dn_vld, dn_src, dn_last, dn_rdy;
  logic [CHNL*LW-1:0]  fifo_level;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bfly_output_merger dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_mode      (cfg_mode),
    .cfg_burst_len (cfg_burst_len),
    .up_vld_A      (up_vld_A),
    .up_dat_A      (up_dat_A),
    .up_rdy_A      (up_rdy_A),
    .up_vld_B      (up_vld_B),
    .up_dat_B      (up_dat_B),
    .up_rdy_B      (up_rdy_B),
    .dn_vld        (dn_vld),
    .dn_dat        (dn_dat),
    .dn_src        (dn_src),
    .dn_last       (dn_last),
    .dn_rdy        (dn_rdy),
    .fifo_level    (fifo_level)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] dat_of(input int ch, input int src, input int seq);
    return {224'd0, 8'(ch), 8'(src), 16'(seq)};
  endfunction

  int ia, ib, k, cyc;
  int seqA[CHNL], seqB[CHNL], rxA[CHNL], rxB[CHNL];
  logic [CHNL-1:0] accA, accB;
  logic [7:0] exp_last;
  logic s;

  initial begin
    rst = 1'b1; cfg_mode = 2'd0; cfg_burst_len = 8'd4;
    up_vld_A = '1; up_vld_B = '0; up_dat_A = '0; up_dat_B = '0; dn_rdy = '0;
    for (int c = 0; c < CHNL; c++) up_dat_A[c*DW +: 32] = 32'h10 + c;

    // Reset behaviour
    repeat (3) begin
      @(negedge clk); #1;
      check("rst_rdyA", up_rdy_A, 0);
      check("rst_rdyB", up_rdy_B, 0);
      check("rst_dnvld", dn_vld, 0);
      check("rst_level", fifo_level, 0);
      check("rst_dndat", |dn_dat, 0);
    end
    @(negedge clk); rst = 1'b0; #1;
    check("post_rst_dnvld", dn_vld, 0);
    check("post_rst_rdyA", up_rdy_A, 8'hFF);
    @(negedge clk); up_vld_A = '0; dn_rdy = '1; #1;
    check("first_dnvld", dn_vld, 8'hFF);
    check("first_dat_ch3", dn_dat[3*DW +: DW], 256'h13);
    check("first_level_ch5", fifo_level[5*LW +: LW], 1);
    @(negedge clk); dn_rdy = '0; up_dat_A = '0; #1;
    check("popped_dnvld", dn_vld, 0);
    check("popped_level", fifo_level, 0);

    // FIXED_A: A drains first, then B
    cfg_mode = 2'd0; ia = 0; ib = 0;
    repeat (12) begin
      @(negedge clk);
      up_vld_A[0] = (ia < 4); up_dat_A[31:0] = 32'hA0 + ia;
      up_vld_B[0] = (ib < 4); up_dat_B[31:0] = 32'hB0 + ib;
      #1;
      if (up_vld_A[0] && up_rdy_A[0]) ia++;
      if (up_vld_B[0] && up_rdy_B[0]) ib++;
    end
    check("t2_level", fifo_level[0 +: LW], 8);
    k = 0;
    repeat (12) begin
      @(negedge clk); up_vld_A[0] = 1'b0; up_vld_B[0] = 1'b0; dn_rdy[0] = 1'b1; #1;
      if (dn_vld[0]) begin
        check("t2_dat", dn_dat[DW-1:0], (k < 4) ? 256'(32'hA0 + k) : 256'(32'hB0 + k - 4));
        check("t2_src", dn_src[0], (k >= 4));
        check("t2_last", dn_last[0], 1);
        k++;
      end
    end
    check("t2_cnt", k, 8);

    // RR fill to full, then full-boundary read
    @(negedge clk); dn_rdy[0] = 1'b0;
    cfg_mode = 2'd1; ia = 0; ib = 0;
    repeat (20) begin
      @(negedge clk);
      up_vld_A[0] = 1'b1; up_dat_A[31:0] = 32'hA0 + ia;
      up_vld_B[0] = 1'b1; up_dat_B[31:0] = 32'hB0 + ib;
      #1;
      if (up_vld_A[0] && up_rdy_A[0]) ia++;
      if (up_vld_B[0] && up_rdy_B[0]) ib++;
    end
    check("t3_level", fifo_level[0 +: LW], 16);
    check("t3_rdyA_full", up_rdy_A[0], 0);
    check("t3_rdyB_full", up_rdy_B[0], 0);
    check("t3_ia", ia, 8);
    check("t3_ib", ib, 8);
    @(negedge clk); dn_rdy[0] = 1'b1; #1;
    check("t5_rdyA_rd_cycle", up_rdy_A[0], 0);
    check("t5_head", dn_dat[DW-1:0], 256'hA0);
    @(negedge clk); dn_rdy[0] = 1'b0; up_dat_A[31:0] = 32'hA0 + ia; #1;
    check("t5_level", fifo_level[0 +: LW], 15);
    check("t5_rdyA", up_rdy_A[0], 1);
    check("t5_rdyB", up_rdy_B[0], 0);
    k = 0;
    repeat (24) begin
      @(negedge clk); up_vld_A[0] = 1'b0; up_vld_B[0] = 1'b0; dn_rdy[0] = 1'b1; #1;
      if (dn_vld[0]) begin
        check("t3_dat", dn_dat[DW-1:0],
              (k % 2 == 0) ? 256'(32'hB0 + k / 2) : 256'(32'hA0 + (k + 1) / 2));
        check("t3_src", dn_src[0], (k % 2 == 0));
        k++;
      end
    end
    check("t3_cnt", k, 16);

    // BURST len=4, B first, len changed mid-burst
    @(negedge clk); dn_rdy[0] = 1'b0;
    cfg_mode = 2'd2; cfg_burst_len = 8'd4; ia = 0; ib = 0; cyc = 0;
    repeat (16) begin
      @(negedge clk);
      up_vld_B[0] = (ib < 4); up_dat_B[31:0] = 32'hB0 + ib;
      up_vld_A[0] = (ia < 4) && (cyc >= 1); up_dat_A[31:0] = 32'hA0 + ia;
      if (ib >= 2) cfg_burst_len = 8'd2;
      #1;
      if (up_vld_A[0] && up_rdy_A[0]) ia++;
      if (up_vld_B[0] && up_rdy_B[0]) ib++;
      cyc++;
    end
    exp_last = 8'b1010_1000;
    k = 0;
    repeat (16) begin
      @(negedge clk); up_vld_A[0] = 1'b0; up_vld_B[0] = 1'b0; dn_rdy[0] = 1'b1; #1;
      if (dn_vld[0]) begin
        check("t4_dat", dn_dat[DW-1:0], (k < 4) ? 256'(32'hB0 + k) : 256'(32'hA0 + k - 4));
        check("t4_src", dn_src[0], (k < 4));
        check("t4_last", dn_last[0], exp_last[k]);
        k++;
      end
    end
    check("t4_cnt", k, 8);

    // Random traffic on all channels, RR mode
    cfg_mode = 2'd1; accA = '0; accB = '0;
    up_vld_A = '0; up_vld_B = '0; up_dat_A = '0; up_dat_B = '0;
    for (int c = 0; c < CHNL; c++) begin seqA[c] = 0; seqB[c] = 0; rxA[c] = 0; rxB[c] = 0; end
    for (int t = 0; t < 10200; t++) begin
      @(negedge clk);
      for (int c = 0; c < CHNL; c++) begin
        if (accA[c]) seqA[c]++;
        if (accB[c]) seqB[c]++;
        if (!up_vld_A[c] || accA[c]) up_vld_A[c] = (t < 10000) && ($urandom_range(1) == 1);
        if (!up_vld_B[c] || accB[c]) up_vld_B[c] = (t < 10000) && ($urandom_range(1) == 1);
        up_dat_A[c*DW +: DW] = dat_of(c, 0, seqA[c]);
        up_dat_B[c*DW +: DW] = dat_of(c, 1, seqB[c]);
        dn_rdy[c] = (t < 10000) ? ($urandom_range(1) == 1) : 1'b1;
      end
      #1;
      for (int c = 0; c < CHNL; c++) begin
        accA[c] = up_vld_A[c] & up_rdy_A[c];
        accB[c] = up_vld_B[c] & up_rdy_B[c];
        if (dn_vld[c] && dn_rdy[c]) begin
          s = dn_src[c];
          check("rnd_x", $isunknown(dn_dat[c*DW +: DW]), 0);
          check("rnd_dat", dn_dat[c*DW +: DW], dat_of(c, int'(s), s ? rxB[c] : rxA[c]));
          if (s) rxB[c]++; else rxA[c]++;
        end
      end
    end
    for (int c = 0; c < CHNL; c++) begin
      if (accA[c]) seqA[c]++;
      if (accB[c]) seqB[c]++;
      check("rnd_cntA", rxA[c], seqA[c]);
      check("rnd_cntB", rxB[c], seqB[c]);
    end
    check("rnd_level_end", fifo_level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
